// File: rtl/mhvpis_pkg.sv
// Shared types and defaults for the vectored priority interrupt controller.
package mhvpis_pkg;
  localparam int NUM_LVL = 4;
  localparam logic [7:0] DEF_VEC_BASE = 8'hF0;
  localparam int DEF_VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    GRANT = 2'b10
  } state_t;

  // Vector address for a level, wrapping modulo 256.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input int stride,
                                        input logic [1:0] idx);
    logic [31:0] s;
    s = 32'(base) + 32'(idx) * 32'(stride);
    return s[7:0];
  endfunction
endpackage

// File: rtl/prio_enc4.sv
// Lowest-index-first 4-bit priority encoder.
module prio_enc4 (
  input  logic [3:0] req,
  output logic       vld,
  output logic [1:0] idx
);
  always_comb begin
    vld = |req;
    idx = 2'd0;
    if (req[0])      idx = 2'd0;
    else if (req[1]) idx = 2'd1;
    else if (req[2]) idx = 2'd2;
    else if (req[3]) idx = 2'd3;
  end
endmodule

// File: rtl/mhvpis_ctrl.sv
// Four-level vectored interrupt controller: edge capture, masking, nesting,
// request/ack handshake to stage 0 and in-service tracking until RTI.
module mhvpis_ctrl
  import mhvpis_pkg::*;
#(
  parameter logic [7:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int         VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_LVL-1:0] irq,
  input  logic [NUM_LVL-1:0] itr_mask,
  input  logic               itr_ack,
  input  logic               itr_done,
  output logic               i_pending,
  output logic [7:0]         vec_addr,
  output logic               vec_valid,
  output logic [2:0]         active_lvl,
  output logic [NUM_LVL-1:0] ipr,
  output logic               spurious_rti
);
  state_t state, nxt;
  logic [3:0] irq_q, isr, below_h, elig, grant_oh, done_oh;
  logic [1:0] gsel, sel_idx, isr_idx;
  logic       sel_vld, isr_vld;

  prio_enc4 u_isr_enc (.req(isr),  .vld(isr_vld), .idx(isr_idx));
  prio_enc4 u_sel_enc (.req(elig), .vld(sel_vld), .idx(sel_idx));

  // Only levels strictly above the highest in-service level may nest.
  always_comb begin
    below_h = 4'hF;
    if (isr_vld) begin
      case (isr_idx)
        2'd0: below_h = 4'b0000;
        2'd1: below_h = 4'b0001;
        2'd2: below_h = 4'b0011;
        default: below_h = 4'b0111;
      endcase
    end
  end

  assign elig     = ipr & itr_mask & below_h;
  assign grant_oh = (state == GRANT) ? 4'(4'b0001 << gsel) : 4'b0000;
  assign done_oh  = (itr_done && isr_vld) ? 4'(4'b0001 << isr_idx) : 4'b0000;

  always_ff @(posedge clk) begin
    if (clr) begin
      irq_q        <= '0;
      ipr          <= '0;
      isr          <= '0;
      spurious_rti <= 1'b0;
      gsel         <= 2'd0;
      vec_addr     <= VEC_BASE;
      state        <= IDLE;
    end else begin
      irq_q <= irq;
      // A fresh rise on the level being granted keeps it pending.
      ipr   <= (ipr & ~grant_oh) | (irq & ~irq_q);
      isr   <= (isr & ~done_oh) | grant_oh;
      if (itr_done && !isr_vld) spurious_rti <= 1'b1;
      state <= nxt;
      if (state == REQ && sel_vld && itr_ack) begin
        gsel     <= sel_idx;
        vec_addr <= vec_of(VEC_BASE, VEC_STRIDE, sel_idx);
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (sel_vld) nxt = REQ;
      REQ:     if (!sel_vld) nxt = IDLE;
               else if (itr_ack) nxt = GRANT;
      GRANT:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign i_pending  = (state == REQ);
  assign vec_valid  = (state == GRANT);
  assign active_lvl = {isr_vld, isr_idx};
endmodule

// File: tb/tb_mhvpis_ctrl.sv
// Directed bench: vector grants checked by a scoreboard monitor, status by direct checks.
module tb_mhvpis_ctrl;
  logic clk = 0, clr = 1;
  logic [3:0] irq = 0, itr_mask = 4'hF;
  logic itr_ack = 0, itr_done = 0;
  logic i_pending, vec_valid, spurious_rti;
  logic [7:0] vec_addr;
  logic [2:0] active_lvl;
  logic [3:0] ipr;

  logic [3:0] irq2 = 0, mask2 = 4'hF;
  logic ack2 = 0, done2 = 0;
  logic i_pending2, vec_valid2, spurious2;
  logic [7:0] vec_addr2;
  logic [2:0] active2;
  logic [3:0] ipr2;

  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];

  always #5 clk = ~clk;

  mhvpis_ctrl dut (
    .clk(clk), .clr(clr), .irq(irq), .itr_mask(itr_mask), .itr_ack(itr_ack),
    .itr_done(itr_done), .i_pending(i_pending), .vec_addr(vec_addr),
    .vec_valid(vec_valid), .active_lvl(active_lvl), .ipr(ipr),
    .spurious_rti(spurious_rti));

  mhvpis_ctrl #(.VEC_BASE(8'hFE), .VEC_STRIDE(4)) dut2 (
    .clk(clk), .clr(clr), .irq(irq2), .itr_mask(mask2), .itr_ack(ack2),
    .itr_done(done2), .i_pending(i_pending2), .vec_addr(vec_addr2),
    .vec_valid(vec_valid2), .active_lvl(active2), .ipr(ipr2),
    .spurious_rti(spurious2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: every vec_valid strobe must match the next queued vector.
  always @(negedge clk) begin
    if (!clr && vec_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vec: got %0h expected none", vec_addr);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (vec_addr !== e) begin
          failures++;
          $display("FAIL vec_addr: got %0h expected %0h", vec_addr, e);
        end
      end
    end
    if (!clr && vec_valid2) begin
      checks++;
      if (exp_q2.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vec2: got %0h expected none", vec_addr2);
      end else begin
        logic [7:0] e;
        e = exp_q2.pop_front();
        if (vec_addr2 !== e) begin
          failures++;
          $display("FAIL vec_addr2: got %0h expected %0h", vec_addr2, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq = v; tick(); irq = 0;
  endtask

  task automatic wait_pending(input string name);
    int n = 0;
    while (!i_pending && n < 20) begin tick(); n++; end
    chk(name, i_pending, 1'b1);
  endtask

  task automatic grant(input logic [7:0] exp);
    exp_q.push_back(exp);
    itr_ack = 1; tick(); itr_ack = 0;
    chk("vec_valid_strobe", vec_valid, 1'b1);
    tick();
    chk("vec_valid_drop", vec_valid, 1'b0);
  endtask

  task automatic rti();
    itr_done = 1; tick(); itr_done = 0;
  endtask

  initial begin
    tick(3);
    clr = 0;
    chk("rst_pending", i_pending, 0);
    chk("rst_vvalid", vec_valid, 0);
    chk("rst_active", active_lvl, 3'b000);
    chk("rst_vaddr", vec_addr, 8'hF0);
    chk("rst_vaddr2", vec_addr2, 8'hFE);
    chk("rst_ipr", ipr, 0);
    chk("rst_spur", spurious_rti, 0);

    // Single grant, level 2; checks the 2-cycle request latency.
    pulse_irq(4'b0100);
    chk("s1_ipr", ipr, 4'b0100);
    chk("s1_pend_early", i_pending, 0);
    tick();
    chk("s1_pend", i_pending, 1);
    grant(8'hF8);
    chk("s1_active", active_lvl, 3'b110);
    chk("s1_ipr_clr", ipr, 4'b0000);
    chk("s1_pend_after", i_pending, 0);
    rti();
    chk("s1_rti", active_lvl, 3'b000);

    // Higher level arriving before ack wins; level 2 blocked until RTI.
    pulse_irq(4'b0100);
    tick();
    chk("s2_pend", i_pending, 1);
    pulse_irq(4'b0010);
    chk("s2_ipr_both", ipr, 4'b0110);
    grant(8'hF4);
    chk("s2_ipr_rem", ipr, 4'b0100);
    chk("s2_active", active_lvl, 3'b101);
    tick(2);
    chk("s2_blocked", i_pending, 0);
    rti();
    wait_pending("s2_pend_after_rti");
    grant(8'hF8);
    rti();
    chk("s2_idle", active_lvl, 3'b000);

    // Masking.
    itr_mask = 4'b1110;
    pulse_irq(4'b0001);
    tick(2);
    chk("s3_masked_pend", i_pending, 0);
    chk("s3_masked_ipr", ipr, 4'b0001);
    itr_mask = 4'hF;
    tick();
    chk("s3_unmask_pend", i_pending, 1);
    grant(8'hF0);
    rti();

    // Nesting level 0 over level 3.
    pulse_irq(4'b1000);
    wait_pending("s4_pend3");
    grant(8'hFC);
    chk("s4_active3", active_lvl, 3'b111);
    pulse_irq(4'b0001);
    wait_pending("s4_pend0");
    grant(8'hF0);
    chk("s4_active_nest", active_lvl, 3'b100);
    rti();
    chk("s4_rti1", active_lvl, 3'b111);
    rti();
    chk("s4_rti2", active_lvl, 3'b000);
    chk("s4_no_spur", spurious_rti, 0);

    // Spurious RTI is sticky.
    rti();
    chk("s5_spur", spurious_rti, 1);
    tick(3);
    chk("s5_spur_sticky", spurious_rti, 1);

    // Vector wrap on the second instance: FE + 1*4 = 02.
    irq2 = 4'b0010; tick(); irq2 = 0;
    begin
      int n = 0;
      while (!i_pending2 && n < 20) begin tick(); n++; end
      chk("s5_pend2", i_pending2, 1);
    end
    exp_q2.push_back(8'h02);
    ack2 = 1; tick(); ack2 = 0;
    chk("s5_vvalid2", vec_valid2, 1);
    tick();
    chk("s5_active2", active2, 3'b101);

    // Reset during REQ with ack asserted: no grant.
    pulse_irq(4'b0100);
    wait_pending("s6_pend");
    clr = 1; itr_ack = 1; tick(); clr = 0; itr_ack = 0;
    chk("s6_pend", i_pending, 0);
    chk("s6_vvalid", vec_valid, 0);
    chk("s6_active", active_lvl, 3'b000);
    chk("s6_ipr", ipr, 4'b0000);
    chk("s6_spur", spurious_rti, 0);
    chk("s6_vaddr", vec_addr, 8'hF0);
    chk("s6_active2", active2, 3'b000);
    tick(3);
    chk("s6_stay_idle", i_pending, 0);

    chk("q_empty", 32'(exp_q.size()), 0);
    chk("q2_empty", 32'(exp_q2.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
